bit_serial_operand_serializer: RTL
==================================

# bit_serial_operand_serializer

Converts parallel K-bit operand pairs into the LSB-first serial bit streams and frame markers (`x`, `y`, `first_bit`, `last_bit`) consumed by `bit_serial_multiplier`. It sits directly upstream of the multiplier. A valid/ready handshake on the parallel side lets frames run back-to-back with no idle cycles. A one-entry holding register decouples the producer from frame timing.

## Interface
- `K`, default 8: operand width in bits; must be ≥ 4. The frame length is F = 2K cycles.
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `s_valid`  in  1  operand pair on `s_x`/`s_y` is valid
- `s_ready`  out  1  serializer can accept a pair this cycle
- `s_x`  in  K  multiplicand, parallel
- `s_y`  in  K  multiplier, parallel
- `x`  out  1  serial multiplicand bit, LSB first
- `y`  out  1  serial multiplier bit, LSB first
- `first_bit`  out  1  high on frame cycle 0
- `last_bit`  out  1  high on frame cycle F-1
- `busy`  out  1  a frame is being emitted

## Operation
- A transfer occurs when `s_valid && s_ready` is high at a rising edge.
- States:
  - IDLE: no frame is active.
  - SHIFT: bit counter `cnt` runs 0..F-1.
- Frame content:
  - Cycles 0..K-1 emit operand bits 0..K-1.
  - Cycles K..F-1 emit pad bits. The pad value is 0 by default (see Configuration).
  - `x` and `y` come from separate F-bit shift registers loaded at frame start.
- Holding register: one entry (`pend_x`, `pend_y`, `pend_full`). `s_ready = !pend_full`.
- IDLE + transfer: load the shifters from `s_x`/`s_y`, `cnt` ← 0, go to SHIFT.
- SHIFT, `cnt < F-1`: shift both registers and increment `cnt`. A transfer in this cycle goes into the holding register.
- SHIFT, `cnt == F-1`:
  - If `pend_full`: load the shifters from the holding register and clear `pend_full`. A transfer in the same cycle then refills the holding register.
  - Else, on a transfer: load directly from `s_x`/`s_y`.
  - Else: go to IDLE.
  - In all three cases `cnt` ← 0.
- In IDLE, `x`, `y`, `first_bit` and `last_bit` are 0.
- `busy` = (state == SHIFT).
- `s_x`/`s_y` are sampled only at the transfer edge; later changes have no effect.

## Timing
- All outputs except `s_ready` are registered. `s_ready` is a direct decode of `pend_full`.
- Latency: a transfer at edge n in IDLE produces `first_bit` = 1, `x` = `s_x[0]` and `y` = `s_y[0]` in the cycle after edge n. `last_bit` follows F-1 cycles later.
- Back-to-back frames: `last_bit` of frame i and `first_bit` of frame i+1 are in adjacent cycles, with no gap.
- `first_bit` and `last_bit` are never high in the same cycle, because F ≥ 8.
- Reset values:
  - `x`, `y`, `first_bit`, `last_bit`, `busy`, `pend_full`: 0.
  - state: IDLE; `cnt`: 0.
  - `s_ready`: 1 once `reset` deasserts. Transfers are ignored while `reset` is high.
- Reset mid-frame: outputs go to 0 asynchronously, and the partial frame and holding entry are discarded. No `last_bit` is emitted for the aborted frame.
- Holding register full (`s_ready` = 0): the producer must hold `s_valid` and its data until a transfer occurs.

## Configuration
- `BIT_SERIAL_SIGN_EXTEND_EN` defined: pad bits in cycles K..F-1 equal the operand MSB (`s_x[K-1]` / `s_y[K-1]`), giving a two's-complement sign extension.
- Not defined: pad bits are 0 (unsigned operation).
- The macro affects only the pad value. Handshake and timing are identical in both cases.

## Structure
- Package `bit_serial_pkg` holds:
  - the state enum (`IDLE`, `SHIFT`);
  - a `clog2`-based counter-width constant function for F = 2K.
- Sub-module `bit_serial_shift_reg` (parameter `W` = F): a loadable, right-shifting register with asynchronous reset and serial output bit 0. It is instantiated twice, once for `x` and once for `y`. Pad generation (zero or sign) is done at the load input.
- The top level contains the FSM, counter, holding register and marker registers.

## Test plan
All scenarios use K = 8 (F = 16).
- Single frame, `s_x` = 0xA5, `s_y` = 0x03:
  - `x` = 1,0,1,0,0,1,0,1 then eight 0s.
  - `y` = 1,1,0,0,0,0,0,0 then eight 0s.
  - `first_bit` high in cycle 1 after the transfer; `last_bit` high in cycle 16 after the transfer.
- Back-to-back, three pairs offered continuously:
  - 48 consecutive `busy` cycles.
  - `first_bit` at offsets 1, 17, 33; `last_bit` at 16, 32, 48.
  - `s_ready` low while the holding register is full.
- Holding-register stall: producer holds `s_valid` with two pending pairs. The second pair is accepted only at the last-bit edge of frame 1, and data stays intact.
- Reset at frame cycle 5 with a pair pending:
  - All outputs 0 immediately; no `last_bit`.
  - After release, `s_ready` = 1 and a new pair 0x01/0x01 frames correctly.
- With `BIT_SERIAL_SIGN_EXTEND_EN`, `s_x` = 0xA5, `s_y` = 0x7F:
  - `x` pad bits are eight 1s.
  - `y` pad bits are eight 0s.
- Idle behaviour: with `s_valid` = 0 for 20 cycles, `x`, `y`, markers and `busy` all stay 0 and `s_ready` stays 1.

Source files
------------

// File: rtl/bit_serial_pkg.sv
// Shared types and helpers for the bit-serial operand serializer.
// Holds the frame FSM state encoding and the frame-counter width helper.
package bit_serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width of a counter that must hold 0..2k-1 (one frame of F = 2k cycles).
  function automatic int cnt_width(input int k);
    return (2 * k <= 2) ? 1 : $clog2(2 * k);
  endfunction

endpackage

// File: rtl/bit_serial_shift_reg.sv
// Loadable right-shifting register; bit 0 is the serial output.
// Zeros are shifted in at the top, so a fully drained register reads 0.
module bit_serial_shift_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] load_data,
  output logic         sout
);

  logic [W-1:0] data;

  // Load has priority over shift; a load starts a fresh frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (shift) begin
      data <= {1'b0, data[W-1:1]};
    end
  end

  assign sout = data[0];

endmodule

// File: rtl/bit_serial_operand_serializer.sv
// Parallel-to-serial front end for bit_serial_multiplier.
// Emits K operand bits LSB first followed by K pad bits per frame (F = 2K),
// with first_bit/last_bit markers and a one-entry holding register so that
// frames can run back-to-back.
// Optional feature: define BIT_SERIAL_SIGN_EXTEND_EN to pad with the operand
// MSB (two's-complement sign extension) instead of zeros.
module bit_serial_operand_serializer
  import bit_serial_pkg::*;
#(
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [K-1:0] s_x,
  input  logic [K-1:0] s_y,
  output logic         x,
  output logic         y,
  output logic         first_bit,
  output logic         last_bit,
  output logic         busy
);

  localparam int F  = 2 * K;
  localparam int CW = cnt_width(K);
  localparam logic [CW-1:0] CNT_LAST   = CW'(F - 1);
  localparam logic [CW-1:0] CNT_PENULT = CW'(F - 2);

  state_t state;
  state_t state_next;

  logic [CW-1:0] cnt;
  logic          xfer;
  logic          at_last;

  logic          load_en;
  logic          load_from_pend;
  logic          shift_en;
  logic          pend_capture;
  logic          pend_release;

  logic          pend_full;
  logic [K-1:0]  pend_x;
  logic [K-1:0]  pend_y;
  logic [K-1:0]  src_x;
  logic [K-1:0]  src_y;

  logic          first_q;
  logic          last_q;

  // Build the full F-bit frame word: operand in the low half, pad above.
  function automatic logic [F-1:0] pad_operand(input logic [K-1:0] v);
`ifdef BIT_SERIAL_SIGN_EXTEND_EN
    return {{K{v[K-1]}}, v};
`else
    return {{K{1'b0}}, v};
`endif
  endfunction

  assign s_ready = !pend_full;
  assign xfer    = s_valid && s_ready;
  assign at_last = (cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: a frame ends in IDLE only when nothing is waiting to follow it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (xfer) state_next = SHIFT;
      SHIFT:   if (at_last && !pend_full && !xfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath controls: load a new frame, shift the current one, or park a pair.
  always_comb begin
    load_en        = 1'b0;
    load_from_pend = 1'b0;
    shift_en       = 1'b0;
    pend_capture   = 1'b0;
    pend_release   = 1'b0;
    case (state)
      IDLE: begin
        load_en = xfer;
      end
      SHIFT: begin
        if (!at_last) begin
          shift_en     = 1'b1;
          pend_capture = xfer;
        end else if (pend_full) begin
          load_en        = 1'b1;
          load_from_pend = 1'b1;
          pend_release   = 1'b1;
          pend_capture   = xfer;
        end else if (xfer) begin
          load_en = 1'b1;
        end else begin
          // Final shift flushes the last pad bit so x/y read 0 in IDLE.
          shift_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign src_x = load_from_pend ? pend_x : s_x;
  assign src_y = load_from_pend ? pend_y : s_y;

  // Frame bit counter: 0 at frame start, wraps at the last bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load_en) begin
      cnt <= '0;
    end else if (state == SHIFT) begin
      cnt <= at_last ? '0 : cnt + CW'(1);
    end
  end

  // Holding register: parks one pair while a frame is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_full <= 1'b0;
      pend_x    <= '0;
      pend_y    <= '0;
    end else if (pend_capture) begin
      pend_full <= 1'b1;
      pend_x    <= s_x;
      pend_y    <= s_y;
    end else if (pend_release) begin
      pend_full <= 1'b0;
    end
  end

  // Frame markers, registered so they line up with the shifter outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      first_q <= load_en;
      last_q  <= (state == SHIFT) && (cnt == CNT_PENULT);
    end
  end

  bit_serial_shift_reg #(.W(F)) u_shift_x (
    .clk       (clk),
    .reset     (reset),
    .load      (load_en),
    .shift     (shift_en),
    .load_data (pad_operand(src_x)),
    .sout      (x)
  );

  bit_serial_shift_reg #(.W(F)) u_shift_y (
    .clk       (clk),
    .reset     (reset),
    .load      (load_en),
    .shift     (shift_en),
    .load_data (pad_operand(src_y)),
    .sout      (y)
  );

  assign first_bit = first_q;
  assign last_bit  = last_q;
  assign busy      = (state == SHIFT);

endmodule
